// File: rtl/npc_state_mux_unit_if.sv
// -----------------------------------------------------------------------------
// npc_state_mux_unit_if
//
// Groups the signals between the NPC core and its state/selection block.
//
//   Register file : rf_wen, rf_waddr, rf_wdata, rf_raddr -> rf_rdata
//   PC register   : pc_wen, pc_din                       -> pc
//   Keyed mux     : mux_key, mux_lut, mux_default        -> mux_out
//
// Modports:
//   master - the core side; drives requests and observes state/results.
//   slave  - the state block; consumes requests and drives state/results.
// -----------------------------------------------------------------------------
interface npc_state_mux_unit_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_KEY     = 8,
    parameter int KEY_LEN    = 7
);
    localparam int PAIR_LEN = KEY_LEN + DATA_WIDTH;

    // Register file
    logic                       rf_wen;
    logic [ADDR_WIDTH-1:0]      rf_waddr;
    logic [DATA_WIDTH-1:0]      rf_wdata;
    logic [ADDR_WIDTH-1:0]      rf_raddr;
    logic [DATA_WIDTH-1:0]      rf_rdata;

    // Program counter
    logic                       pc_wen;
    logic [DATA_WIDTH-1:0]      pc_din;
    logic [DATA_WIDTH-1:0]      pc;

    // Keyed lookup mux
    logic [KEY_LEN-1:0]         mux_key;
    logic [NR_KEY*PAIR_LEN-1:0] mux_lut;
    logic [DATA_WIDTH-1:0]      mux_default;
    logic [DATA_WIDTH-1:0]      mux_out;

    modport master (
        output rf_wen, rf_waddr, rf_wdata, rf_raddr,
        output pc_wen, pc_din,
        output mux_key, mux_lut, mux_default,
        input  rf_rdata, pc, mux_out
    );

    modport slave (
        input  rf_wen, rf_waddr, rf_wdata, rf_raddr,
        input  pc_wen, pc_din,
        input  mux_key, mux_lut, mux_default,
        output rf_rdata, pc, mux_out
    );
endinterface

// File: rtl/npc_state_mux_unit.sv
// -----------------------------------------------------------------------------
// npc_state_mux_unit
//
// Architectural state and opcode-driven selection for the single-cycle NPC
// core:
//   - a 2^ADDR_WIDTH entry register file (one write, one combinational read),
//     entry 0 reads as zero and ignores writes;
//   - the program-counter register, loaded from pc_din when pc_wen is high;
//   - a keyed lookup mux: OR of the data of every matching {key,data} pair,
//     or mux_default when nothing matches.
//
// Ports:
//   clk  - rising-edge clock for all state
//   rst  - asynchronous active-low reset (pc <= RESET_PC, all entries <= 0)
//   bus  - slave side of npc_state_mux_unit_if (register file, PC, mux)
// -----------------------------------------------------------------------------
module npc_state_mux_unit #(
    parameter int                ADDR_WIDTH = 5,
    parameter int                DATA_WIDTH = 32,
    parameter logic [31:0]       RESET_PC   = 32'h8000_0000,
    parameter int                NR_KEY     = 8,
    parameter int                KEY_LEN    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    npc_state_mux_unit_if.slave   bus
);
    localparam int NR_REGS  = 1 << ADDR_WIDTH;
    localparam int DATA_LEN = DATA_WIDTH;
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs [NR_REGS];

    // Entry 0 is cleared on reset and never written, so it stays zero; the
    // read side also forces zero so the hardwiring does not rely on storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.rf_wen && (bus.rf_waddr != '0)) begin
            regs[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    // No write-to-read bypass: a same-cycle write becomes visible after the edge.
    assign bus.rf_rdata = (bus.rf_raddr == '0) ? '0 : regs[bus.rf_raddr];

    // -------------------------------------------------------------------------
    // Program counter
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC[DATA_WIDTH-1:0];
        end else if (bus.pc_wen) begin
            pc_q <= bus.pc_din;
        end
    end

    assign bus.pc = pc_q;

    // -------------------------------------------------------------------------
    // Keyed lookup mux
    // -------------------------------------------------------------------------
    // Pair i sits at mux_lut[i*PAIR_LEN +: PAIR_LEN] with the key in the upper
    // KEY_LEN bits, so pair 0 is the last element of a {..} concatenation.
    function automatic logic [KEY_LEN-1:0] lut_key(
        input logic [NR_KEY*PAIR_LEN-1:0] lut,
        input int                         idx
    );
        return lut[idx*PAIR_LEN+DATA_LEN +: KEY_LEN];
    endfunction

    function automatic logic [DATA_LEN-1:0] lut_data(
        input logic [NR_KEY*PAIR_LEN-1:0] lut,
        input int                         idx
    );
        return lut[idx*PAIR_LEN +: DATA_LEN];
    endfunction

    logic [NR_KEY-1:0]   hit;
    logic [DATA_LEN-1:0] hit_or;

    // Duplicate keys are legal; all hitting data words are OR-merged.
    always_comb begin
        hit    = '0;
        hit_or = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            hit[i] = (bus.mux_key == lut_key(bus.mux_lut, i));
            if (hit[i]) begin
                hit_or = hit_or | lut_data(bus.mux_lut, i);
            end
        end
    end

    assign bus.mux_out = (|hit) ? hit_or : bus.mux_default;

endmodule

// File: tb/tb_npc_state_mux_unit.sv
// -----------------------------------------------------------------------------
// tb_npc_state_mux_unit
//
// Directed bench for npc_state_mux_unit. The stimulus process sets inputs just
// after a rising edge and queues the values the outputs must show in that
// cycle; the monitor drains the queue on every falling edge and compares.
// -----------------------------------------------------------------------------
module tb_npc_state_mux_unit;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NK   = 8;
    localparam int KL   = 7;
    localparam int PAIR = KL + DW;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    localparam int SEL_RF  = 0;
    localparam int SEL_PC  = 1;
    localparam int SEL_MUX = 2;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   checks;
    int   errors;

    npc_state_mux_unit_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_KEY(NK), .KEY_LEN(KL)
    ) bus_if ();

    npc_state_mux_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RST_PC),
        .NR_KEY(NK), .KEY_LEN(KL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                SEL_RF:  act = bus_if.rf_rdata;
                SEL_PC:  act = bus_if.pc;
                default: act = bus_if.mux_out;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input int idx, input logic [6:0] k, input logic [31:0] d);
        bus_if.mux_lut[idx*PAIR +: PAIR] = {k, d};
    endtask

    task automatic mux_check(input string name, input logic [6:0] k, input logic [31:0] v);
        bus_if.mux_key = k;
        expect_val(name, SEL_MUX, v);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst                = 1'b0;
        bus_if.rf_wen      = 1'b0;
        bus_if.rf_waddr    = '0;
        bus_if.rf_wdata    = '0;
        bus_if.rf_raddr    = '0;
        bus_if.pc_wen      = 1'b0;
        bus_if.pc_din      = '0;
        bus_if.mux_key     = '0;
        bus_if.mux_lut     = '0;
        bus_if.mux_default = '0;

        step();
        expect_val("reset_pc_initial", SEL_PC, RST_PC);
        step();
        rst = 1'b1;
        step();

        // Put non-reset state in place so the reset check means something.
        bus_if.rf_wen   = 1'b1;
        bus_if.rf_waddr = 5'd7;
        bus_if.rf_wdata = 32'hA5A5_A5A5;
        bus_if.pc_wen   = 1'b1;
        bus_if.pc_din   = 32'h0000_0040;
        step();
        bus_if.rf_wen   = 1'b0;
        bus_if.pc_wen   = 1'b0;
        bus_if.rf_raddr = 5'd7;
        expect_val("pre_reset_x7", SEL_RF, 32'hA5A5_A5A5);
        expect_val("pre_reset_pc", SEL_PC, 32'h0000_0040);
        step();

        // Reset asserted between edges with a PC load pending.
        bus_if.pc_wen = 1'b1;
        bus_if.pc_din = 32'h0000_1234;
        rst           = 1'b0;
        expect_val("async_reset_pc", SEL_PC, RST_PC);
        expect_val("async_reset_x7", SEL_RF, 32'h0);
        step();
        for (int a = 0; a < 32; a++) begin
            bus_if.rf_raddr = a[AW-1:0];
            expect_val($sformatf("reset_rf_x%0d", a), SEL_RF, 32'h0);
            step();
        end
        expect_val("reset_pc_held", SEL_PC, RST_PC);
        step();

        // Release: PC load happens only at the following edge.
        rst = 1'b1;
        expect_val("release_pc_before_edge", SEL_PC, RST_PC);
        step();
        bus_if.pc_wen = 1'b0;
        expect_val("release_pc_loaded", SEL_PC, 32'h0000_1234);
        step();

        // Register file: write x5, then try x0.
        bus_if.rf_wen   = 1'b1;
        bus_if.rf_waddr = 5'd5;
        bus_if.rf_wdata = 32'hDEAD_BEEF;
        bus_if.rf_raddr = 5'd5;
        expect_val("rf_no_bypass_x5", SEL_RF, 32'h0);
        step();
        bus_if.rf_waddr = 5'd0;
        bus_if.rf_wdata = 32'h1111_1111;
        expect_val("rf_x5_written", SEL_RF, 32'hDEAD_BEEF);
        step();
        bus_if.rf_wen   = 1'b0;
        bus_if.rf_raddr = 5'd0;
        expect_val("rf_x0_zero", SEL_RF, 32'h0);
        step();

        // PC hold and load.
        bus_if.pc_wen = 1'b1;
        bus_if.pc_din = 32'h8000_0000;
        step();
        bus_if.pc_wen = 1'b0;
        bus_if.pc_din = 32'h8000_0010;
        expect_val("pc_set_base", SEL_PC, 32'h8000_0000);
        step();
        expect_val("pc_hold", SEL_PC, 32'h8000_0000);
        step();
        bus_if.pc_wen = 1'b1;
        expect_val("pc_no_comb_path", SEL_PC, 32'h8000_0000);
        step();
        bus_if.pc_wen = 1'b0;
        expect_val("pc_load", SEL_PC, 32'h8000_0010);
        step();

        // Mux: opcode table.
        set_pair(0, 7'h33, 32'h8000_0004);
        set_pair(1, 7'h13, 32'h8000_0004);
        set_pair(2, 7'h03, 32'h8000_0004);
        set_pair(3, 7'h23, 32'h8000_0004);
        set_pair(4, 7'h37, 32'h8000_0004);
        set_pair(5, 7'h63, 32'h8000_0100);
        set_pair(6, 7'h6F, 32'h8000_0100);
        set_pair(7, 7'h67, 32'h8000_0100);
        bus_if.mux_default = 32'hCAFE_F00D;
        mux_check("mux_hit_6f", 7'h6F, 32'h8000_0100);
        mux_check("mux_hit_13", 7'h13, 32'h8000_0004);
        mux_check("mux_hit_pair0", 7'h33, 32'h8000_0004);
        mux_check("mux_hit_pair7", 7'h67, 32'h8000_0100);
        mux_check("mux_miss_default", 7'h73, 32'hCAFE_F00D);

        // Duplicate keys OR-merge; RF write and PC load share one edge.
        for (int i = 0; i < NK; i++) begin
            set_pair(i, 7'h40 + 7'(i), 32'h0000_1000 << i);
        end
        set_pair(2, 7'h13, 32'h0000_00F0);
        set_pair(5, 7'h13, 32'h0000_000F);
        bus_if.mux_key  = 7'h13;
        bus_if.rf_wen   = 1'b1;
        bus_if.rf_waddr = 5'd31;
        bus_if.rf_wdata = 32'h3131_3131;
        bus_if.rf_raddr = 5'd31;
        bus_if.pc_wen   = 1'b1;
        bus_if.pc_din   = 32'h0000_2000;
        expect_val("mux_duplicate_or", SEL_MUX, 32'h0000_00FF);
        expect_val("simul_x31_old", SEL_RF, 32'h0);
        step();
        bus_if.rf_wen = 1'b0;
        bus_if.pc_wen = 1'b0;
        expect_val("simul_x31_written", SEL_RF, 32'h3131_3131);
        expect_val("simul_pc_loaded", SEL_PC, 32'h0000_2000);
        mux_check("mux_unique_41", 7'h41, 32'h0000_2000);
        bus_if.rf_raddr = 5'd5;
        expect_val("rf_x5_kept", SEL_RF, 32'hDEAD_BEEF);
        step();

        // Reset asserted mid-cycle overrides a pending write.
        bus_if.rf_wen   = 1'b1;
        bus_if.rf_waddr = 5'd9;
        bus_if.rf_wdata = 32'h9999_9999;
        bus_if.rf_raddr = 5'd9;
        #2;
        rst = 1'b0;
        step();
        rst           = 1'b1;
        bus_if.rf_wen = 1'b0;
        expect_val("reset_overrides_write", SEL_RF, 32'h0);
        step();

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
